mux_ff_ex: RTL and testbench
============================

MUX_FF_EX -- requirements
Module: mux_ff_ex

Interface
REQ-001 Parameter: WIDTH, default 1, data width of i0..i3 and q; the bench uses the default.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: resetn  input  1  reset, active-low, asynchronous.
REQ-004 Port: i0  input  WIDTH  data input, selected when sel=0.
REQ-005 Port: i1  input  WIDTH  data input, selected when sel=1.
REQ-006 Port: i2  input  WIDTH  data input, selected when sel=2.
REQ-007 Port: i3  input  WIDTH  data input, selected when sel=3.
REQ-008 Port: sel  input  2  select code.
REQ-009 Port: q  output  WIDTH  registered mux output.
REQ-010 Positional port order SHALL be: i0, i1, i2, i3, clk, resetn, sel, q.
REQ-011 One clock (clk); resetn SHALL be asynchronous and active-low.

Function
REQ-012 The block SHALL implement a 4:1 combinational mux: sel 0/1/2/3 selects i0/i1/i2/i3.
REQ-013 The mux result SHALL be captured into q on every rising edge of clk while resetn=1.
- Latency: 1 cycle from sel/data valid at an edge to q.
REQ-014 q SHALL change only on a rising clk edge or on assertion of resetn, never combinationally from sel or i*.
REQ-015 Simulation semantics: X or Z on the selected input SHALL propagate unchanged into q.
- No resolution to 0/1.
- Unselected inputs SHALL NOT affect q.
REQ-016 An X or Z on sel SHALL produce X on q in simulation at the next edge.
REQ-017 No enable, handshake, or state machine; q updates every cycle.

Reset
REQ-018 While resetn=0, q SHALL be all-zero, regardless of clk, sel and i*.
REQ-019 Assertion of resetn SHALL clear q immediately, without waiting for a clock edge.
- This includes reset asserted mid-operation.
REQ-020 Deassertion of resetn SHALL take effect for the first rising edge at which resetn=1.
- The first post-reset capture occurs at that edge.

Structure
REQ-021 No shared package is required.
- The select encoding (SEL_I0..SEL_I3 = 0..3) MAY be placed in a shared package if other mux blocks reuse it.
REQ-022 The implementation SHALL be a single module: combinational mux feeding one asynchronously reset register.
- A sub-module mux4 for the combinational selector is optional.

Verification
REQ-023 Reset: resetn=0 from t=0, clk 10 ns period (first rising edge at 5 ns) -> q=0 at 5 ns and throughout reset.
REQ-024 Select i0: inputs i0=0, i1=1, i2=X, i3=Z; resetn=1 at 6 ns, sel=0 -> q=0 after the edge at 15 ns.
REQ-025 Select i1: sel=1 set at 26 ns -> q=1 after the edge at 35 ns.
REQ-026 Select i2: sel=2 set at 46 ns -> q=X after the edge at 55 ns; the bench SHALL check with case equality (===).
REQ-027 Select i3: sel=3 set at 66 ns -> q=Z after the edge at 75 ns; the bench SHALL check with ===.
REQ-028 Async reset mid-run: with q=1, drive resetn=0 between edges -> q=0 immediately.
- q SHALL stay 0 until the first edge after resetn=1.

Source files
------------

// File: rtl/mux_ff_ex_pkg.sv
// rtl/mux_ff_ex_pkg.sv - select encoding shared by the mux_ff_ex family
package mux_ff_ex_pkg;

   localparam int SEL_W = 2;

   typedef enum logic [SEL_W-1:0] {
      SEL_I0 = 2'd0,
      SEL_I1 = 2'd1,
      SEL_I2 = 2'd2,
      SEL_I3 = 2'd3
   } sel_e;

endpackage

// File: rtl/mux_ff_ex_if.sv
// rtl/mux_ff_ex_if.sv - data/select/output bundle for mux_ff_ex
interface mux_ff_ex_if
   import mux_ff_ex_pkg::*;
#(
   parameter int WIDTH = 1
);

   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic [WIDTH-1:0] i2;
   logic [WIDTH-1:0] i3;
   logic [SEL_W-1:0] sel;
   logic [WIDTH-1:0] q;

   // Source of data and select; observes the registered result.
   modport master (
      output i0, i1, i2, i3, sel,
      input  q
   );

   // The mux register itself.
   modport slave (
      input  i0, i1, i2, i3, sel,
      output q
   );

endinterface

// File: rtl/mux_ff_ex_mux4.sv
// rtl/mux_ff_ex_mux4.sv - combinational 4:1 selector
module mux_ff_ex_mux4
   import mux_ff_ex_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] y
);

   // Plain assignment passes X/Z on the chosen input through untouched;
   // an unknown select falls to the default and yields X rather than a guess.
   always_comb begin
      y = '0;
      case (sel)
         SEL_I0:  y = i0;
         SEL_I1:  y = i1;
         SEL_I2:  y = i2;
         SEL_I3:  y = i3;
         default: y = 'x;
      endcase
   end

endmodule

// File: rtl/mux_ff_ex.sv
// rtl/mux_ff_ex.sv - 4:1 mux feeding one asynchronously reset register
module mux_ff_ex
   import mux_ff_ex_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic [WIDTH-1:0] i2,
   input  logic [WIDTH-1:0] i3,
   input  logic             clk,
   input  logic             resetn,
   input  logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] mux_y;

   mux_ff_ex_mux4 #(
      .WIDTH (WIDTH)
   ) u_mux4 (
      .i0  (i0),
      .i1  (i1),
      .i2  (i2),
      .i3  (i3),
      .sel (sel),
      .y   (mux_y)
   );

   // Capture the selection every edge; reset clears q at once, without a clock.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         q <= '0;
      end else begin
         q <= mux_y;
      end
   end

endmodule

// File: tb/tb_mux_ff_ex.sv
// tb/tb_mux_ff_ex.sv - scoreboard bench for mux_ff_ex
module tb_mux_ff_ex;

   localparam int W = 1;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_v;
   logic [W-1:0] last_exp;

   mux_ff_ex_if #(.WIDTH(W)) bus ();

   mux_ff_ex #(
      .WIDTH (W)
   ) dut (
      .i0     (bus.i0),
      .i1     (bus.i1),
      .i2     (bus.i2),
      .i3     (bus.i3),
      .clk    (clk),
      .resetn (resetn),
      .sel    (bus.sel),
      .q      (bus.q)
   );

   // 10 ns clock, first rising edge at 5 ns
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [W-1:0] ref_mux(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d,
                                            input logic [1:0] s);
      logic [W-1:0] v [4];
      if ($isunknown(s)) return 'x;
      v[0] = a;
      v[1] = b;
      v[2] = c;
      v[3] = d;
      return v[s];
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d,
                        input logic [1:0] s);
      bus.i0  = a;
      bus.i1  = b;
      bus.i2  = c;
      bus.i3  = d;
      bus.sel = s;
      exp_q.push_back(ref_mux(a, b, c, d, s));
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (bus.q !== '0) begin
         errors++;
         $display("FAIL reset_t1: q=%b expected %b", bus.q, 1'b0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.q !== '0) begin
         errors++;
         $display("FAIL reset_edge: q=%b expected %b", bus.q, 1'b0);
      end
   endtask

   task automatic test_sel_i0();
      resetn = 1'b1;
      drive(1'b0, 1'b1, 1'bx, 1'bz, 2'd0);
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sel_i0: scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         last_exp = exp_v;
         if (bus.q !== exp_v) begin
            errors++;
            $display("FAIL sel_i0: q=%b expected %b", bus.q, exp_v);
         end
      end
   endtask

   task automatic test_sel_code(input logic [1:0] s, input string name);
      @(posedge clk);
      #1;
      drive(bus.i0, bus.i1, bus.i2, bus.i3, s);
      #1;
      checks++;
      if (bus.q !== last_exp) begin
         errors++;
         $display("FAIL %s_hold: q=%b expected %b", name, bus.q, last_exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         exp_v = exp_q.pop_front();
         last_exp = exp_v;
         if (bus.q !== exp_v) begin
            errors++;
            $display("FAIL %s: q=%b expected %b", name, bus.q, exp_v);
         end
      end
   endtask

   task automatic test_sel_unknown();
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 2'bxx);
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sel_x: scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         if (bus.q !== exp_v) begin
            errors++;
            $display("FAIL sel_x: q=%b expected %b", bus.q, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
      @(posedge clk);
      #1;
      checks++;
      exp_v = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      if (bus.q !== exp_v || exp_v !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: q=%b expected %b", bus.q, 1'b1);
      end
      #2;
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.q !== '0) begin
         errors++;
         $display("FAIL arst_immediate: q=%b expected %b", bus.q, 1'b0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.q !== '0) begin
         errors++;
         $display("FAIL arst_hold_edge: q=%b expected %b", bus.q, 1'b0);
      end
      #2;
      resetn = 1'b1;
      exp_q.push_back(ref_mux(bus.i0, bus.i1, bus.i2, bus.i3, bus.sel));
      #1;
      checks++;
      if (bus.q !== '0) begin
         errors++;
         $display("FAIL arst_release_hold: q=%b expected %b", bus.q, 1'b0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL arst_first_capture: scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         if (bus.q !== exp_v) begin
            errors++;
            $display("FAIL arst_first_capture: q=%b expected %b", bus.q, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 24; k++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            checks++;
            exp_v = exp_q.pop_front();
            if (bus.q !== exp_v) begin
               errors++;
               $display("FAIL b2b_%0d: q=%b expected %b", k, bus.q, exp_v);
            end
         end
         drive(W'($urandom_range(1)), W'($urandom_range(1)), W'($urandom_range(1)),
               W'($urandom_range(1)), 2'($urandom_range(3)));
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL b2b_last: scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         if (bus.q !== exp_v) begin
            errors++;
            $display("FAIL b2b_last: q=%b expected %b", bus.q, exp_v);
         end
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      last_exp = '0;
      resetn   = 1'b0;
      bus.i0   = 1'b0;
      bus.i1   = 1'b1;
      bus.i2   = 1'bx;
      bus.i3   = 1'bz;
      bus.sel  = 2'd0;
      test_reset();
      test_sel_i0();
      test_sel_code(2'd1, "sel_i1");
      test_sel_code(2'd2, "sel_i2");
      test_sel_code(2'd3, "sel_i3");
      test_sel_unknown();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
